// File: rtl/fft_twiddle_mult_pkg.sv
// Shared widths, fixed-point constants and sample type for the FFT twiddle multiplier.
// Samples are Q1.15, twiddles Q2.14; products are renormalised by TW_FRAC bits.
package fft_twiddle_mult_pkg;

    localparam int DATA_W   = 16;
    localparam int TW_W     = 16;
    localparam int ADDR_W   = 5;
    localparam int TW_DEPTH = 28;

    localparam int TW_FRAC  = 14;
    localparam int ACC_W    = DATA_W + TW_W + 1;

    // Half an output LSB, added before the shift for round-half-up.
    localparam logic signed [ACC_W-1:0]  RND_CONST = ACC_W'(2 ** (TW_FRAC - 1));
    localparam logic signed [DATA_W-1:0] SAT_MAX   = DATA_W'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [DATA_W-1:0] SAT_MIN   = DATA_W'(-(2 ** (DATA_W - 1)));

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;

endpackage

// File: rtl/fft_cmult_round_sat.sv
// Complex multiply by a twiddle with round-half-up and saturation.
// E2 registers the four partial products, E3 registers the rounded/saturated result.
module fft_cmult_round_sat #(
    parameter int DATA_W = fft_twiddle_mult_pkg::DATA_W,
    parameter int TW_W   = fft_twiddle_mult_pkg::TW_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_vld,
    input  logic                     i_last,
    input  logic signed [DATA_W-1:0] i_re,
    input  logic signed [DATA_W-1:0] i_im,
    input  logic signed [TW_W-1:0]   i_c,
    input  logic signed [TW_W-1:0]   i_d,
    output logic                     o_vld,
    output logic                     o_last,
    output logic signed [DATA_W-1:0] o_re,
    output logic signed [DATA_W-1:0] o_im,
    output logic                     o_sat_hit
);
    import fft_twiddle_mult_pkg::*;

    localparam int PROD_W = DATA_W + TW_W;
    localparam int SUM_W  = PROD_W + 1;
    localparam logic signed [SUM_W-1:0] LIM_HI = SUM_W'(SAT_MAX);
    localparam logic signed [SUM_W-1:0] LIM_LO = SUM_W'(SAT_MIN);

    function automatic logic signed [SUM_W-1:0] round_shift(input logic signed [SUM_W-1:0] acc);
        logic signed [SUM_W-1:0] biased;
        biased = acc + SUM_W'(RND_CONST);
        return biased >>> TW_FRAC;
    endfunction

    function automatic logic clipped(input logic signed [SUM_W-1:0] v);
        return (v > LIM_HI) || (v < LIM_LO);
    endfunction

    function automatic logic signed [DATA_W-1:0] saturate(input logic signed [SUM_W-1:0] v);
        logic signed [DATA_W-1:0] res;
        if (v > LIM_HI) begin
            res = LIM_HI[DATA_W-1:0];
        end else if (v < LIM_LO) begin
            res = LIM_LO[DATA_W-1:0];
        end else begin
            res = v[DATA_W-1:0];
        end
        return res;
    endfunction

    logic                     r_vld_p2;
    logic                     r_last_p2;
    logic signed [PROD_W-1:0] r_prr_p2;
    logic signed [PROD_W-1:0] r_pii_p2;
    logic signed [PROD_W-1:0] r_prd_p2;
    logic signed [PROD_W-1:0] r_pic_p2;
    logic                     r_vld_p3;
    logic                     r_last_p3;
    logic signed [DATA_W-1:0] r_re_p3;
    logic signed [DATA_W-1:0] r_im_p3;
    logic signed [SUM_W-1:0]  w_re_rnd;
    logic signed [SUM_W-1:0]  w_im_rnd;
    logic                     w_clip_re;
    logic                     w_clip_im;

    // E2: partial products
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p2 <= 1'b0;
        end else begin
            r_vld_p2 <= i_vld;
        end
    end

    always_ff @(posedge clk) begin
        if (i_vld) begin
            r_prr_p2  <= PROD_W'(i_re) * PROD_W'(i_c);
            r_pii_p2  <= PROD_W'(i_im) * PROD_W'(i_d);
            r_prd_p2  <= PROD_W'(i_re) * PROD_W'(i_d);
            r_pic_p2  <= PROD_W'(i_im) * PROD_W'(i_c);
            r_last_p2 <= i_last;
        end
    end

    always_comb begin
        w_re_rnd  = round_shift(SUM_W'(r_prr_p2) - SUM_W'(r_pii_p2));
        w_im_rnd  = round_shift(SUM_W'(r_prd_p2) + SUM_W'(r_pic_p2));
        w_clip_re = clipped(w_re_rnd);
        w_clip_im = clipped(w_im_rnd);
    end

    // E3: rounded, saturated outputs; held while no sample arrives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p3  <= 1'b0;
            r_last_p3 <= 1'b0;
            r_re_p3   <= '0;
            r_im_p3   <= '0;
        end else begin
            r_vld_p3 <= r_vld_p2;
            if (r_vld_p2) begin
                r_last_p3 <= r_last_p2;
                r_re_p3   <= saturate(w_re_rnd);
                r_im_p3   <= saturate(w_im_rnd);
            end
        end
    end

    assign o_sat_hit = r_vld_p2 && (w_clip_re || w_clip_im);
    assign o_vld     = r_vld_p3;
    assign o_last    = r_last_p3;
    assign o_re      = r_re_p3;
    assign o_im      = r_im_p3;

endmodule

// File: rtl/fft_twiddle_mult.sv
// FFT twiddle multiplier: fetches w from an external synchronous ROM pair and
// streams x*w with a fixed 4-cycle latency, plus sticky error flags and a frame counter.
module fft_twiddle_mult #(
    parameter int DATA_W   = fft_twiddle_mult_pkg::DATA_W,
    parameter int TW_W     = fft_twiddle_mult_pkg::TW_W,
    parameter int ADDR_W   = fft_twiddle_mult_pkg::ADDR_W,
    parameter int TW_DEPTH = fft_twiddle_mult_pkg::TW_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_re,
    input  logic signed [DATA_W-1:0] in_im,
    input  logic [ADDR_W-1:0]        in_tw_idx,
    input  logic                     in_last,
    input  logic                     clear_flags,
    output logic [ADDR_W-1:0]        tw_addr,
    input  logic signed [TW_W-1:0]   tw_re_data,
    input  logic signed [TW_W-1:0]   tw_im_data,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_re,
    output logic signed [DATA_W-1:0] out_im,
    output logic                     out_last,
    output logic                     sat_flag,
    output logic                     idx_err,
    output logic [7:0]               frame_cnt
);
    import fft_twiddle_mult_pkg::*;

    // One extra bit so a depth equal to 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(TW_DEPTH);

    logic              r_vld_p0;
    logic              r_vld_p1;
    logic              r_last_p0;
    logic              r_last_p1;
    cplx_t             r_smp_p0;
    cplx_t             r_smp_p1;
    logic [ADDR_W-1:0] r_tw_addr;
    logic              r_sat_flag;
    logic              r_idx_err;
    logic [7:0]        r_frame_cnt;
    logic              w_idx_bad;
    logic              w_sat_hit;
    logic              w_out_valid;
    logic              w_out_last;

    assign w_idx_bad = in_valid && ({1'b0, in_tw_idx} >= DEPTH_LIM);

    // E0: issue ROM address, capture sample; E1: ROM data lands alongside the sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p0  <= 1'b0;
            r_vld_p1  <= 1'b0;
            r_tw_addr <= '0;
        end else begin
            r_vld_p0 <= in_valid;
            r_vld_p1 <= r_vld_p0;
            if (in_valid) begin
                r_tw_addr <= in_tw_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid) begin
            r_smp_p0.re <= in_re;
            r_smp_p0.im <= in_im;
            r_last_p0   <= in_last;
        end
        if (r_vld_p0) begin
            r_smp_p1  <= r_smp_p0;
            r_last_p1 <= r_last_p0;
        end
    end

    fft_cmult_round_sat #(
        .DATA_W (DATA_W),
        .TW_W   (TW_W)
    ) u_cmult (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_vld     (r_vld_p1),
        .i_last    (r_last_p1),
        .i_re      (r_smp_p1.re),
        .i_im      (r_smp_p1.im),
        .i_c       (tw_re_data),
        .i_d       (tw_im_data),
        .o_vld     (w_out_valid),
        .o_last    (w_out_last),
        .o_re      (out_re),
        .o_im      (out_im),
        .o_sat_hit (w_sat_hit)
    );

    // Sticky flags: a new event on the same edge as clear_flags keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_flag  <= 1'b0;
            r_idx_err   <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            if (w_sat_hit) begin
                r_sat_flag <= 1'b1;
            end else if (clear_flags) begin
                r_sat_flag <= 1'b0;
            end
            if (w_idx_bad) begin
                r_idx_err <= 1'b1;
            end else if (clear_flags) begin
                r_idx_err <= 1'b0;
            end
            if (w_out_valid && w_out_last) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    assign tw_addr   = r_tw_addr;
    assign out_valid = w_out_valid;
    assign out_last  = w_out_last;
    assign sat_flag  = r_sat_flag;
    assign idx_err   = r_idx_err;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_fft_twiddle_mult.sv
// Directed bench for fft_twiddle_mult with a behavioural 1-cycle twiddle ROM pair.
`timescale 1ns/1ps
module tb_fft_twiddle_mult;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_re = '0;
    logic [15:0] in_im = '0;
    logic [4:0]  in_tw_idx = '0;
    logic        in_last = 1'b0;
    logic        clear_flags = 1'b0;
    logic [4:0]  tw_addr;
    logic [15:0] tw_re_data;
    logic [15:0] tw_im_data;
    logic        out_valid;
    logic [15:0] out_re;
    logic [15:0] out_im;
    logic        out_last;
    logic        sat_flag;
    logic        idx_err;
    logic [7:0]  frame_cnt;

    logic [15:0] rom_re [32];
    logic [15:0] rom_im [32];

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        tw_re_data <= rom_re[tw_addr];
        tw_im_data <= rom_im[tw_addr];
    end

    fft_twiddle_mult dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_re       (in_re),
        .in_im       (in_im),
        .in_tw_idx   (in_tw_idx),
        .in_last     (in_last),
        .clear_flags (clear_flags),
        .tw_addr     (tw_addr),
        .tw_re_data  (tw_re_data),
        .tw_im_data  (tw_im_data),
        .out_valid   (out_valid),
        .out_re      (out_re),
        .out_im      (out_im),
        .out_last    (out_last),
        .sat_flag    (sat_flag),
        .idx_err     (idx_err),
        .frame_cnt   (frame_cnt)
    );

    typedef struct {
        logic [4:0]  idx;
        logic [15:0] c;
        logic [15:0] d;
        logic [15:0] re;
        logic [15:0] im;
        logic [15:0] exp_re;
        logic [15:0] exp_im;
        logic        exp_sat;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv, nlast, nerr, vk, j;
        logic [15:0] cap_re, cap_im;

        // idx, c, d, re, im, exp_re, exp_im, exp_sat
        vecs[0] = '{5'd0, 16'h4000, 16'h0000, 16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b0};
        vecs[1] = '{5'd1, 16'h0000, 16'hC000, 16'h2000, 16'h1000, 16'h1000, 16'hE000, 1'b0};
        vecs[2] = '{5'd2, 16'h4000, 16'hC000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000, 1'b1};
        vecs[3] = '{5'd3, 16'h2D41, 16'hD2BF, 16'h1000, 16'h0000, 16'h0B50, 16'hF4B0, 1'b0};
        vecs[4] = '{5'd4, 16'h8000, 16'h0000, 16'h7FFF, 16'h0000, 16'h8000, 16'h0000, 1'b1};
        vecs[5] = '{5'd5, 16'h0001, 16'h0000, 16'h2000, 16'hE000, 16'h0001, 16'h0000, 1'b0};
        vecs[6] = '{5'd6, 16'h4000, 16'h4000, 16'h1000, 16'h0800, 16'h0800, 16'h1800, 1'b0};

        for (int i = 0; i < 32; i++) begin
            rom_re[i] = '0;
            rom_im[i] = '0;
        end
        for (int i = 0; i < 7; i++) begin
            rom_re[vecs[i].idx] = vecs[i].c;
            rom_im[vecs[i].idx] = vecs[i].d;
        end

        // Power-on reset
        #3 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_re", out_re, 0);
        chk("rst_out_im", out_im, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_tw_addr", tw_addr, 0);
        chk("rst_flags", {sat_flag, idx_err}, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single-sample vectors with latency, hold and flag checks
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_tw_idx = vecs[i].idx;
            in_re = vecs[i].re;
            in_im = vecs[i].im;
            tick();
            in_valid = 1'b0;
            tick();
            tick();
            chk($sformatf("v%0d_not_early", i), out_valid, 0);
            tick();
            chk($sformatf("v%0d_valid", i), out_valid, 1);
            chk($sformatf("v%0d_re", i), out_re, vecs[i].exp_re);
            chk($sformatf("v%0d_im", i), out_im, vecs[i].exp_im);
            chk($sformatf("v%0d_sat", i), sat_flag, vecs[i].exp_sat);
            chk($sformatf("v%0d_addr_hold", i), tw_addr, vecs[i].idx);
            tick();
            chk($sformatf("v%0d_valid_drop", i), out_valid, 0);
            chk($sformatf("v%0d_re_hold", i), out_re, vecs[i].exp_re);
            clear_flags = 1'b1;
            tick();
            clear_flags = 1'b0;
            chk($sformatf("v%0d_sat_cleared", i), sat_flag, 0);
        end

        // Saturation coinciding with clear_flags: set wins
        in_valid = 1'b1;
        in_tw_idx = 5'd2;
        in_re = 16'h7FFF;
        in_im = 16'h7FFF;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        chk("sat_set_wins", sat_flag, 1);
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        chk("sat_clear_after", sat_flag, 0);

        // 28-sample frame streamed back to back through identity twiddles
        for (int i = 0; i < 32; i++) begin
            rom_re[i] = (i < 28) ? 16'h4000 : 16'h0000;
            rom_im[i] = '0;
        end
        chk("frame_cnt_pre", frame_cnt, 0);
        nv = 0;
        nlast = 0;
        nerr = 0;
        for (int k = 0; k < 36; k++) begin
            if (k < 28) begin
                in_valid = 1'b1;
                in_tw_idx = 5'(k);
                in_re = 16'(k * 256 + 3);
                in_im = 16'(-k * 7);
                in_last = (k == 27);
            end else begin
                in_valid = 1'b0;
                in_last = 1'b0;
            end
            tick();
            j = k - 3;
            if (out_valid) begin
                nv++;
                if (j < 0 || j > 27) nerr++;
                else if (out_re !== 16'(j * 256 + 3) || out_im !== 16'(-j * 7)) nerr++;
                if (out_last) begin
                    nlast++;
                    if (j != 27) nerr++;
                end
            end else if (j >= 0 && j <= 27) begin
                nerr++;
            end
        end
        chk("stream_valid_count", nv, 28);
        chk("stream_last_count", nlast, 1);
        chk("stream_errors", nerr, 0);
        chk("frame_cnt_post", frame_cnt, 1);

        // Out-of-range twiddle index
        in_valid = 1'b1;
        in_tw_idx = 5'd30;
        in_re = 16'h4000;
        in_im = 16'h4000;
        tick();
        in_valid = 1'b0;
        chk("idx30_err", idx_err, 1);
        tick();
        tick();
        tick();
        chk("idx30_valid", out_valid, 1);
        chk("idx30_out", {out_re, out_im}, 0);
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        chk("idx_err_cleared", idx_err, 0);
        in_valid = 1'b1;
        in_tw_idx = 5'd27;
        tick();
        in_valid = 1'b0;
        chk("idx27_no_err", idx_err, 0);
        in_valid = 1'b1;
        in_tw_idx = 5'd28;
        clear_flags = 1'b1;
        tick();
        in_valid = 1'b0;
        clear_flags = 1'b0;
        chk("idx_err_set_wins", idx_err, 1);
        repeat (4) tick();

        // Load non-zero state, then reset in the middle of a stream
        rom_re[2] = 16'h4000;
        rom_im[2] = 16'hC000;
        in_valid = 1'b1;
        in_tw_idx = 5'd2;
        in_re = 16'h7FFF;
        in_im = 16'h7FFF;
        in_last = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last = 1'b0;
        repeat (5) tick();
        chk("pre_rst_state", {sat_flag, out_last, frame_cnt}, {1'b1, 1'b1, 8'd2});
        in_valid = 1'b1;
        in_tw_idx = 5'd30;
        in_re = 16'h1111;
        in_im = 16'h2222;
        tick();
        in_tw_idx = 5'd5;
        tick();
        in_tw_idx = 5'd6;
        rst_n = 1'b0;
        #1;
        chk("midrst_tw_addr", tw_addr, 0);
        chk("midrst_out", {out_valid, out_last, out_re, out_im}, 0);
        chk("midrst_flags", {sat_flag, idx_err}, 0);
        chk("midrst_frame_cnt", frame_cnt, 0);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        in_valid = 1'b1;
        in_tw_idx = 5'd1;
        in_re = 16'h0100;
        in_im = 16'h0080;
        nv = 0;
        vk = 0;
        cap_re = '0;
        cap_im = '0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1) in_valid = 1'b0;
            if (out_valid) begin
                nv++;
                vk = k;
                cap_re = out_re;
                cap_im = out_im;
            end
        end
        chk("postrst_valid_count", nv, 1);
        chk("postrst_latency", vk, 4);
        chk("postrst_data", {cap_re, cap_im}, {16'h0100, 16'h0080});

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/fft_twiddle_mult.md
FFT_TWIDDLE_MULT -- requirements
Module: fft_twiddle_mult

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning signed sample width (Q1.15).
REQ-002 The block SHALL have parameter TW_W, default 16, meaning signed twiddle width (Q2.14).
REQ-003 The block SHALL have parameter ADDR_W, default 5, meaning twiddle ROM address width.
REQ-004 The block SHALL have parameter TW_DEPTH, default 28, meaning number of valid ROM entries.
REQ-005 The block SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-007 The block SHALL have port in_valid, input, 1, meaning the input sample is present this cycle; no backpressure.
REQ-008 The block SHALL have ports in_re and in_im, input, DATA_W each, meaning the complex input sample.
REQ-009 The block SHALL have port in_tw_idx, input, ADDR_W, meaning the twiddle index for this sample.
REQ-010 The block SHALL have port in_last, input, 1, meaning the last sample of a frame.
REQ-011 The block SHALL have port clear_flags, input, 1, meaning a synchronous pulse that clears sticky flags.
REQ-012 The block SHALL have port tw_addr, output, ADDR_W, meaning the shared address to the real and imaginary twiddle ROMs (1-cycle synchronous read).
REQ-013 The block SHALL have ports tw_re_data and tw_im_data, input, TW_W each, meaning the registered ROM outputs.
REQ-014 The block SHALL have port out_valid, output, 1, meaning the output product is valid.
REQ-015 The block SHALL have ports out_re and out_im, output, DATA_W each, meaning the product sample x*w.
REQ-016 The block SHALL have port out_last, output, 1, meaning in_last delayed and aligned with out_valid.
REQ-017 The block SHALL have port sat_flag, output, 1, meaning sticky: some output saturated.
REQ-018 The block SHALL have port idx_err, output, 1, meaning sticky: an accepted index was >= TW_DEPTH.
REQ-019 The block SHALL have port frame_cnt, output, 8, meaning completed output frames, wrapping 255->0.

Function
REQ-020 The block SHALL run a 4-stage pipeline on accepted samples (in_valid=1) with no stalls:
- E0: register tw_addr<=in_tw_idx, sample, valid, last.
- E1: ROM presents data; sample/valid/last advance one stage.
- E2: register the four products re*c, im*d, re*d, im*c (32-bit signed).
- E3: register the outputs.
REQ-021 The block SHALL assert out_valid exactly 4 cycles after the in_valid cycle, for every sample, including back-to-back streaming at 1 sample/clock.
REQ-022 The block SHALL hold tw_addr at its last value when in_valid=0.
REQ-023 The block SHALL compute out_re=(re*c - im*d) and out_im=(re*d + im*c) in 33-bit signed arithmetic, add 2^13, arithmetic-shift right by 14, then saturate to [-32768, 32767].
REQ-024 The block SHALL set sat_flag on any clipped component; when set and clear_flags coincide, set wins.
REQ-025 The block SHALL set idx_err when an accepted in_tw_idx >= TW_DEPTH, still issue the address, and multiply by the returned data (0).
REQ-026 The block SHALL increment frame_cnt on each cycle with out_valid and out_last both 1.
REQ-027 The block SHALL hold out_re, out_im and out_last at their previous values while out_valid=0.

Reset
REQ-028 The block SHALL, on rst_n low, immediately clear all stage valids, out_valid, out_last, out_re, out_im, tw_addr, sat_flag, idx_err and frame_cnt to 0.
REQ-029 The block SHALL discard in-flight samples on reset mid-stream, produce no outputs for them after release, and accept in_valid on the first edge after release.

Structure
REQ-030 A shared package SHALL hold DATA_W, TW_W, ADDR_W, TW_DEPTH, the rounding constant, the saturation limits, and a complex-sample struct typedef.
REQ-031 The block SHALL instantiate one sub-module, fft_cmult_round_sat, holding the product/sum/round/saturate stages E2-E3; the ROMs stay outside the block.

Verification
REQ-032 Directed test: idx 0 with ROM (0x4000,0x0000), in=(0x4000,0x0000) -> out=(0x4000,0x0000) 4 cycles later; sat_flag=0.
REQ-033 Directed test: ROM (0x0000,0xC000), in=(0x2000,0x1000) -> out=(0x1000,0xE000) (multiply by -j).
REQ-034 Directed test: ROM (0x4000,0xC000), in=(0x7FFF,0x7FFF) -> out=(0x7FFF,0x0000); sat_flag=1 until clear_flags.
REQ-035 Directed test: 28 back-to-back samples, idx 0..27, in_last on the 28th -> 28 consecutive out_valid, out_last on the 28th only, frame_cnt 0->1.
REQ-036 Directed test: in_tw_idx=30 -> idx_err=1, output (0,0); a simultaneous clear_flags and new error leaves idx_err=1.
REQ-037 Directed test: rst_n low 2 cycles into a stream -> all outputs 0 immediately; no stale out_valid after release.
